// File: rtl/traffic_pkg.sv
// Shared light codes, fault causes, dwell limits and light-code helpers
// for the traffic conflict monitor.
package traffic_pkg;

    localparam int NUM_DIRS = 2;  // index 0 = North-South, 1 = East-West

    localparam logic [3:0] LIGHT_LEFT   = 4'b1001;
    localparam logic [3:0] LIGHT_GREEN  = 4'b0100;
    localparam logic [3:0] LIGHT_YELLOW = 4'b0010;
    localparam logic [3:0] LIGHT_RED    = 4'b0001;

    localparam logic [4:0] LIMIT_LEFT   = 5'd5;
    localparam logic [4:0] LIMIT_GREEN  = 5'd10;
    localparam logic [4:0] LIMIT_YELLOW = 5'd3;
    localparam logic [4:0] LIMIT_RED    = 5'd24;

    localparam logic [4:0] DWELL_MAX    = 5'd31;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_ILLEGAL  = 3'd1,
        FC_CONFLICT = 3'd2,
        FC_EMERG    = 3'd3,
        FC_SEQ      = 3'd4,
        FC_TIMEOUT  = 3'd5
    } fault_code_e;

    typedef struct packed {
        logic illegal;
        logic seq;
        logic timeout;
    } dir_flags_t;

    function automatic logic is_legal(input logic [3:0] c);
        return (c == LIGHT_LEFT) || (c == LIGHT_GREEN) ||
               (c == LIGHT_YELLOW) || (c == LIGHT_RED);
    endfunction

    // Holding a code and dropping to RED are always allowed; YELLOW->RED
    // is covered by the latter.
    function automatic logic legal_step(input logic [3:0] prev, input logic [3:0] cur);
        return (cur == prev) || (cur == LIGHT_RED) ||
               (prev == LIGHT_LEFT  && cur == LIGHT_GREEN)  ||
               (prev == LIGHT_GREEN && cur == LIGHT_YELLOW) ||
               (prev == LIGHT_RED   && cur == LIGHT_LEFT);
    endfunction

    // Illegal codes get the saturation value so they never time out;
    // they are already reported as ILLEGAL.
    function automatic logic [4:0] dwell_limit(input logic [3:0] c);
        case (c)
            LIGHT_LEFT:   return LIMIT_LEFT;
            LIGHT_GREEN:  return LIMIT_GREEN;
            LIGHT_YELLOW: return LIMIT_YELLOW;
            LIGHT_RED:    return LIMIT_RED;
            default:      return DWELL_MAX;
        endcase
    endfunction

endpackage

// File: rtl/light_dir_checker.sv
// Per-direction checker: code legality, transition legality and dwell timing.
// Flags are combinational on the current sample and the registered history.
module light_dir_checker
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] code,
    input  logic       emergency,
    output dir_flags_t flags
);

    logic [3:0] prev_code;
    logic       prev_valid;
    logic [4:0] dwell;
    logic [4:0] dwell_nxt;

    // Dwell count including the current sample, and the three flags.
    always_comb begin
        dwell_nxt = dwell;
        if (!prev_valid || code != prev_code)
            dwell_nxt = 5'd1;
        else if (!emergency && dwell != DWELL_MAX)
            dwell_nxt = dwell + 5'd1;

        flags.illegal = !is_legal(code);
        flags.seq     = prev_valid && !legal_step(prev_code, code);
        flags.timeout = dwell_nxt > dwell_limit(code);
    end

    // History keeps tracking regardless of any latched fault.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_code  <= 4'd0;
            prev_valid <= 1'b0;
            dwell      <= 5'd0;
        end else begin
            prev_code  <= code;
            prev_valid <= 1'b1;
            dwell      <= dwell_nxt;
        end
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Watches both light controllers, resolves the highest-priority violation
// each cycle and latches the first one as a sticky fault.
module traffic_conflict_monitor
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ns_light,
    input  logic [3:0] ew_light,
    input  logic       emergency,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_dir,
    output logic       force_allstop
);

    logic       [NUM_DIRS-1:0][3:0] light;
    dir_flags_t [NUM_DIRS-1:0]      flags;
    logic       [NUM_DIRS-1:0]      illegal_v, seq_v, tmo_v, not_red;

    logic        emerg_d;
    fault_code_e viol_code;
    logic [1:0]  viol_dir;
    fault_code_e fault_code_q;

    assign light = {ew_light, ns_light};

    generate
        for (genvar g = 0; g < NUM_DIRS; g++) begin : g_dir
            light_dir_checker u_chk (
                .clk       (clk),
                .rst_n     (rst_n),
                .code      (light[g]),
                .emergency (emergency),
                .flags     (flags[g])
            );
        end
    endgenerate

    // Flatten per-direction flags into direction bit-vectors.
    always_comb begin
        illegal_v = '0;
        seq_v     = '0;
        tmo_v     = '0;
        not_red   = '0;
        for (int i = 0; i < NUM_DIRS; i++) begin
            illegal_v[i] = flags[i].illegal;
            seq_v[i]     = flags[i].seq;
            tmo_v[i]     = flags[i].timeout;
            not_red[i]   = light[i] != LIGHT_RED;
        end
    end

    // Priority: ILLEGAL > CONFLICT > EMERG > SEQ > TIMEOUT.
    always_comb begin
        viol_code = FC_NONE;
        viol_dir  = 2'b00;
        if (|illegal_v) begin
            viol_code = FC_ILLEGAL;
            viol_dir  = illegal_v;
        end else if (&not_red) begin
            viol_code = FC_CONFLICT;
            viol_dir  = 2'b11;
        end else if (emerg_d && |not_red) begin
            viol_code = FC_EMERG;
            viol_dir  = not_red;
        end else if (|seq_v) begin
            viol_code = FC_SEQ;
            viol_dir  = seq_v;
        end else if (|tmo_v) begin
            viol_code = FC_TIMEOUT;
            viol_dir  = tmo_v;
        end
    end

    // Sticky fault latch; a violation on the clear edge wins over the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            emerg_d      <= 1'b0;
            fault        <= 1'b0;
            fault_code_q <= FC_NONE;
            fault_dir    <= 2'b00;
        end else begin
            emerg_d <= emergency;
            if (viol_code != FC_NONE && (!fault || fault_clr)) begin
                fault        <= 1'b1;
                fault_code_q <= viol_code;
                fault_dir    <= viol_dir;
            end else if (fault_clr) begin
                fault        <= 1'b0;
                fault_code_q <= FC_NONE;
                fault_dir    <= 2'b00;
            end
        end
    end

    assign fault_code    = fault_code_q;
    assign force_allstop = fault;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a monitor
// pops one per clock and compares against the DUT.
module tb_traffic_conflict_monitor;

    localparam logic [3:0] L = 4'b1001, G = 4'b0100, Y = 4'b0010, R = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] ns_light = 4'b0001, ew_light = 4'b0001;
    logic       emergency = 1'b0, fault_clr = 1'b0;
    logic       fault, force_allstop;
    logic [2:0] fault_code;
    logic [1:0] fault_dir;

    traffic_conflict_monitor dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ns_light      (ns_light),
        .ew_light      (ew_light),
        .emergency     (emergency),
        .fault_clr     (fault_clr),
        .fault         (fault),
        .fault_code    (fault_code),
        .fault_dir     (fault_dir),
        .force_allstop (force_allstop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    fault, code, dir;
        bit    dchk;
        int    dfault, dcode, ddir;
        string nm;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;

    // Reference model state (plain integers, spec-level rules).
    int m_prev[2], m_dwell[2];
    bit m_pv = 0, m_emd = 0;
    int m_fault = 0, m_code = 0, m_dir = 0;

    function automatic bit legal(int c);
        return c == 9 || c == 4 || c == 2 || c == 1;
    endfunction

    function automatic int limit(int c);
        case (c)
            9: return 5;
            4: return 10;
            2: return 3;
            1: return 24;
            default: return 1000;
        endcase
    endfunction

    function automatic bit succ(int p, int c);
        if (c == p || c == 1) return 1;
        return (p == 9 && c == 4) || (p == 4 && c == 2) || (p == 1 && c == 9);
    endfunction

    function automatic logic [3:0] next_legal(logic [3:0] c);
        case (c)
            L: return G;
            G: return Y;
            Y: return R;
            R: return L;
            default: return R;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] ns, input logic [3:0] ew, input bit em,
                        input bit clr, input bit rs, input bit dchk = 0,
                        input int dfault = 0, input int dcode = 0, input int ddir = 0,
                        input string nm = "rand");
        exp_t e;
        int cur[2], nd[2];
        int il, sq, to, nr, vc, vd;
        @(negedge clk);
        ns_light = ns; ew_light = ew; emergency = em; fault_clr = clr; rst_n = rs;
        if (!rs) begin
            m_pv = 0; m_emd = 0; m_dwell = '{0, 0};
            m_fault = 0; m_code = 0; m_dir = 0;
        end else begin
            cur[0] = int'(ns); cur[1] = int'(ew);
            il = 0; sq = 0; to = 0; nr = 0;
            for (int d = 0; d < 2; d++) begin
                if (!m_pv || cur[d] != m_prev[d]) nd[d] = 1;
                else if (em)                      nd[d] = m_dwell[d];
                else                              nd[d] = (m_dwell[d] < 31) ? m_dwell[d] + 1 : 31;
                if (!legal(cur[d]))                    il |= 1 << d;
                if (m_pv && !succ(m_prev[d], cur[d]))  sq |= 1 << d;
                if (nd[d] > limit(cur[d]))             to |= 1 << d;
                if (cur[d] != 1)                       nr |= 1 << d;
            end
            vc = 0; vd = 0;
            if (il != 0)              begin vc = 1; vd = il; end
            else if (nr == 3)         begin vc = 2; vd = 3;  end
            else if (m_emd && nr != 0) begin vc = 3; vd = nr; end
            else if (sq != 0)         begin vc = 4; vd = sq; end
            else if (to != 0)         begin vc = 5; vd = to; end
            if (vc != 0 && (m_fault == 0 || clr)) begin
                m_fault = 1; m_code = vc; m_dir = vd;
            end else if (clr) begin
                m_fault = 0; m_code = 0; m_dir = 0;
            end
            m_prev = cur; m_dwell = nd; m_pv = 1; m_emd = em;
        end
        e.fault = m_fault; e.code = m_code; e.dir = m_dir;
        e.dchk = dchk; e.dfault = dfault; e.dcode = dcode; e.ddir = ddir; e.nm = nm;
        q.push_back(e);
    endtask

    // Monitor: one expectation per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.nm, "/fault"}, int'(fault), e.fault);
                chk({e.nm, "/code"}, int'(fault_code), e.code);
                chk({e.nm, "/dir"}, int'(fault_dir), e.dir);
                chk({e.nm, "/allstop"}, int'(force_allstop), e.fault);
                if (e.dchk) begin
                    chk({e.nm, "/d_fault"}, int'(fault), e.dfault);
                    chk({e.nm, "/d_code"}, int'(fault_code), e.dcode);
                    chk({e.nm, "/d_dir"}, int'(fault_dir), e.ddir);
                end
            end
        end
    end

    initial begin
        logic [3:0] codes[4];
        logic [3:0] c[2];
        int r, wait_cyc;
        codes = '{L, G, Y, R};

        step(R, R, 0, 0, 0);
        step(R, R, 0, 0, 0, 1, 0, 0, 0, "reset");

        // Three rounds of a normal phased cycle.
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int i = 0; i < 5;  i++) step(L, R, 0, 0, 1);
            for (int i = 0; i < 10; i++) step(G, R, 0, 0, 1);
            for (int i = 0; i < 3;  i++) step(Y, R, 0, 0, 1);
            for (int i = 0; i < 5;  i++) step(R, L, 0, 0, 1);
            for (int i = 0; i < 10; i++) step(R, G, 0, 0, 1);
            for (int i = 0; i < 3;  i++) step(R, Y, 0, 0, 1);
        end
        step(R, R, 0, 0, 1, 1, 0, 0, 0, "normal");

        step(G, L, 0, 0, 1, 1, 1, 2, 3, "conflict");
        step(R, L, 0, 1, 1, 1, 0, 0, 0, "clear1");

        step(L, R, 0, 0, 1);
        step(G, R, 1, 0, 1);
        step(G, R, 0, 0, 1, 1, 1, 3, 1, "emerg");
        step(R, R, 0, 1, 1, 1, 0, 0, 0, "clear2");

        step(R, L, 0, 0, 1);
        step(R, G, 0, 0, 1);
        step(R, L, 0, 0, 1, 1, 1, 4, 2, "seq");
        step(R, G, 0, 1, 1, 1, 0, 0, 0, "clear3");
        step(R, Y, 0, 0, 1);
        step(R, Y, 0, 0, 1);
        step(R, Y, 0, 0, 1, 1, 0, 0, 0, "yellow3");
        step(R, Y, 0, 0, 1, 1, 1, 5, 2, "timeout");

        step(R, R, 0, 1, 1);
        step(4'b0110, G, 0, 0, 1, 1, 1, 1, 1, "illegal");
        step(R, R, 0, 0, 1, 1, 1, 1, 1, "sticky");
        step(G, L, 0, 1, 1, 1, 1, 2, 3, "clr_vs_set");
        step(4'b0110, R, 0, 0, 1, 1, 1, 2, 3, "no_overwrite");

        step(R, R, 0, 1, 1);
        step(R, L, 0, 0, 1);
        step(R, G, 0, 0, 1);
        step(G, G, 0, 0, 1);
        step(R, G, 1, 1, 0, 1, 0, 0, 0, "mid_reset");
        step(R, L, 0, 0, 1, 1, 0, 0, 0, "post_reset");

        // Randomized mostly-legal traffic with occasional faults and resets.
        c[0] = R; c[1] = L;
        for (int n = 0; n < 1500; n++) begin
            for (int d = 0; d < 2; d++) begin
                r = $urandom_range(0, 99);
                if (r < 60)      c[d] = c[d];
                else if (r < 85) c[d] = next_legal(c[d]);
                else if (r < 95) c[d] = codes[$urandom_range(0, 3)];
                else             c[d] = 4'($urandom_range(0, 15));
            end
            step(c[0], c[1], $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 49) != 0);
        end

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
